// File: rtl/pmp_pkg.sv
// Shared encodings and the result record for the sequential PMP checker.
// The checker scans the PMP entries a few lanes at a time, and lower entries take priority.
package pmp_pkg;

  typedef enum logic [1:0] {
    A_OFF   = 2'd0,
    A_TOR   = 2'd1,
    A_NA4   = 2'd2,
    A_NAPOT = 2'd3
  } pmp_a_e;

  typedef enum logic [1:0] {
    CMD_READ  = 2'd0,
    CMD_WRITE = 2'd1,
    CMD_EXEC  = 2'd2,
    CMD_RSVD  = 2'd3
  } pmp_cmd_e;

  localparam int CFG_R    = 0;
  localparam int CFG_W    = 1;
  localparam int CFG_X    = 2;
  localparam int CFG_A_LO = 3;
  localparam int CFG_L    = 7;

  localparam logic [1:0] PRV_M = 2'd3;

  // Sized for the largest supported table (64 entries).
  localparam int IDX_MAX_W = 6;

  typedef struct packed {
    logic                 r;
    logic                 w;
    logic                 x;
    logic                 fault;
    logic                 hit;
    logic [IDX_MAX_W-1:0] idx;
  } pmp_result_t;

  // The reserved command always faults. Other commands fault when their permission is missing.
  function automatic logic cmd_fault(input logic [1:0] cmd, input logic r, input logic w,
                                     input logic x);
    unique case (pmp_cmd_e'(cmd))
      CMD_READ:  return ~r;
      CMD_WRITE: return ~w;
      CMD_EXEC:  return ~x;
      CMD_RSVD:  return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/pmp_entry_match.sv
// Combinational region decode for one PMP entry.
// It reports whether the access range [addr, end_addr] touches the region, and whether it lies fully inside.
module pmp_entry_match
  import pmp_pkg::*;
#(
  parameter int ADDR_W = 34
) (
  input  logic [7:0]        cfg,
  input  logic [ADDR_W-3:0] pmp_addr,
  input  logic [ADDR_W-3:0] prev_addr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [ADDR_W-1:0] end_addr,
  output logic              any_match,
  output logic              full_match
);

  localparam int PW = ADDR_W - 2;

  logic [ADDR_W-1:0] lo;
  logic [ADDR_W:0]   last;
  logic              valid;
  logic [PW-1:0]     ones;
  logic              unused_cfg;

  assign unused_cfg = ^{cfg[7:5], cfg[2:0]};

  // The region is held as an inclusive [lo, last] pair, one bit wider than the address.
  // An all-ones NAPOT can then cover the whole space.
  always_comb begin
    ones  = pmp_addr & ~(pmp_addr + PW'(1));
    valid = 1'b0;
    lo    = '0;
    last  = '0;
    unique case (pmp_a_e'(cfg[CFG_A_LO +: 2]))
      A_OFF: ;
      A_TOR: begin
        valid = pmp_addr > prev_addr;
        lo    = {prev_addr, 2'b00};
        last  = {1'b0, pmp_addr, 2'b00} - (ADDR_W+1)'(1);
      end
      A_NA4: begin
        valid = 1'b1;
        lo    = {pmp_addr, 2'b00};
        last  = {1'b0, pmp_addr, 2'b11};
      end
      A_NAPOT: begin
        valid = 1'b1;
        lo    = {pmp_addr & ~ones, 2'b00};
        last  = {1'b0, lo} | {ones, 3'b111};
      end
    endcase
    any_match  = valid && ({1'b0, addr} <= last) && (end_addr >= lo);
    full_match = valid && (addr >= lo) && ({1'b0, end_addr} <= last);
  end

endmodule

// File: rtl/pmp_scan_checker.sv
// Sequential PMP checker that evaluates LANES entries per cycle, with lowest index winning.
// Group match results go through a stage register before the permission and fault result is formed.
module pmp_scan_checker
  import pmp_pkg::*;
#(
  parameter int NUM_ENTRIES = 16,
  parameter int ADDR_W      = 34,
  parameter int LANES       = 4
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic [1:0]                        req_prv,
  input  logic [ADDR_W-1:0]                 req_addr,
  input  logic [1:0]                        req_size,
  input  logic [1:0]                        req_cmd,
  input  logic                              kill,
  input  logic [NUM_ENTRIES*8-1:0]          pmp_cfg,
  input  logic [NUM_ENTRIES*(ADDR_W-2)-1:0] pmp_addr,
  output logic                              busy,
  output logic                              resp_valid,
  input  logic                              resp_ready,
  output logic                              resp_r,
  output logic                              resp_w,
  output logic                              resp_x,
  output logic                              resp_fault,
  output logic                              resp_hit,
  output logic [$clog2(NUM_ENTRIES)-1:0]    resp_idx
);

  localparam int PW         = ADDR_W - 2;
  localparam int IDX_W      = $clog2(NUM_ENTRIES);
  localparam int NUM_GROUPS = NUM_ENTRIES / LANES;
  localparam int GRP_W      = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
  localparam logic [GRP_W-1:0] LAST_GROUP = GRP_W'(NUM_GROUPS - 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_RESP} state_e;

  state_e            state_q, state_d;
  logic [GRP_W-1:0]  group_q, group_d;
  pmp_result_t       res_q, res_d, scan_res;

  logic [1:0]        prv_q, cmd_q;
  logic [ADDR_W-1:0] addr_q, end_q;
  logic [ADDR_W:0]   end_full;
  logic              accept;

  logic              stg_valid_q, stg_hit_q, stg_partial_q, stg_last_q;
  logic [IDX_W-1:0]  stg_idx_q;
  logic [3:0]        stg_perm_q;   // {L, X, W, R}

  logic [LANES-1:0]  lane_any, lane_full;
  logic [IDX_W-1:0]  lane_idx [LANES];
  logic [7:0]        lane_cfg [LANES];

  logic              grp_hit, grp_partial;
  logic [IDX_W-1:0]  win_idx;
  logic [3:0]        win_perm;
  logic              unused_idx;

  assign accept   = (state_q == S_IDLE) && req_valid;
  assign end_full = {1'b0, req_addr} + ((ADDR_W+1)'(1) << req_size) - (ADDR_W+1)'(1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prv_q  <= '0;
      cmd_q  <= '0;
      addr_q <= '0;
      end_q  <= '0;
    end else if (accept) begin
      prv_q  <= req_prv;
      cmd_q  <= req_cmd;
      addr_q <= req_addr;
      end_q  <= end_full[ADDR_W-1:0];
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [IDX_W-1:0] idx, prev_idx;
    logic [PW-1:0]    cur, prev;

    // Lane 0 reads the previous entry across the group boundary, so TOR works for it too.
    always_comb begin
      idx      = IDX_W'(int'(group_q) * LANES + l);
      prev_idx = idx - IDX_W'(1);
      cur      = pmp_addr[int'(idx) * PW +: PW];
      prev     = (idx == '0) ? '0 : pmp_addr[int'(prev_idx) * PW +: PW];
    end

    assign lane_idx[l] = idx;
    assign lane_cfg[l] = pmp_cfg[int'(idx) * 8 +: 8];

    pmp_entry_match #(.ADDR_W(ADDR_W)) u_match (
      .cfg        (lane_cfg[l]),
      .pmp_addr   (cur),
      .prev_addr  (prev),
      .addr       (addr_q),
      .end_addr   (end_q),
      .any_match  (lane_any[l]),
      .full_match (lane_full[l])
    );
  end

  // NOTE: every output of a combinational block gets a default first, so a missed branch cannot infer a latch.
  always_comb begin
    grp_hit     = 1'b0;
    grp_partial = 1'b0;
    win_idx     = '0;
    win_perm    = '0;
    for (int l = 0; l < LANES; l++) begin
      if (!grp_hit && lane_any[l]) begin
        grp_hit     = 1'b1;
        grp_partial = !lane_full[l];
        win_idx     = lane_idx[l];
        win_perm    = {lane_cfg[l][CFG_L], lane_cfg[l][CFG_X], lane_cfg[l][CFG_W], lane_cfg[l][CFG_R]};
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stg_valid_q   <= 1'b0;
      stg_hit_q     <= 1'b0;
      stg_partial_q <= 1'b0;
      stg_last_q    <= 1'b0;
      stg_idx_q     <= '0;
      stg_perm_q    <= '0;
    end else begin
      stg_valid_q   <= (state_q == S_SCAN);
      stg_hit_q     <= grp_hit;
      stg_partial_q <= grp_partial;
      stg_last_q    <= (group_q == LAST_GROUP);
      stg_idx_q     <= win_idx;
      stg_perm_q    <= win_perm;
    end
  end

  // M-mode bypasses unlocked entries. A partial match removes all permissions.
  always_comb begin
    logic is_m, ignore;
    is_m     = (prv_q == PRV_M);
    ignore   = is_m && !stg_perm_q[3];
    scan_res = '0;
    if (stg_hit_q) begin
      scan_res.r   = (stg_perm_q[0] | ignore) & ~stg_partial_q;
      scan_res.w   = (stg_perm_q[1] | ignore) & ~stg_partial_q;
      scan_res.x   = (stg_perm_q[2] | ignore) & ~stg_partial_q;
      scan_res.hit = 1'b1;
      scan_res.idx = IDX_MAX_W'(stg_idx_q);
    end else begin
      scan_res.r = is_m;
      scan_res.w = is_m;
      scan_res.x = is_m;
    end
    scan_res.fault = cmd_fault(cmd_q, scan_res.r, scan_res.w, scan_res.x);
  end

  always_comb begin
    state_d = state_q;
    group_d = group_q;
    res_d   = res_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          group_d = '0;
          if (end_full[ADDR_W]) begin
            state_d       = S_RESP;
            res_d         = '0;
            res_d.fault   = 1'b1;
          end else begin
            state_d = S_SCAN;
          end
        end
      end
      S_SCAN: begin
        if (kill) begin
          state_d = S_IDLE;
          res_d   = '0;
        end else begin
          if (group_q != LAST_GROUP) group_d = group_q + GRP_W'(1);
          if (stg_valid_q && (stg_hit_q || stg_last_q)) begin
            state_d = S_RESP;
            res_d   = scan_res;
          end
        end
      end
      S_RESP: begin
        if (kill || resp_ready) begin
          state_d = S_IDLE;
          res_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      group_q <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      group_q <= group_d;
      res_q   <= res_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_r     = res_q.r;
  assign resp_w     = res_q.w;
  assign resp_x     = res_q.x;
  assign resp_fault = res_q.fault;
  assign resp_hit   = res_q.hit;
  assign resp_idx   = res_q.idx[IDX_W-1:0];
  assign unused_idx = ^res_q.idx;

endmodule

// File: tb/tb_pmp_scan_checker.sv
// Randomized and directed bench for pmp_scan_checker.
// Its reference model works from byte ranges and plain integer arithmetic.
module tb_pmp_scan_checker;

  localparam int NE = 16;
  localparam int AW = 34;
  localparam int LN = 4;
  localparam int PW = AW - 2;
  localparam longint SPACE = 64'h4_0000_0000;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [1:0]        req_prv = '0;
  logic [AW-1:0]     req_addr = '0;
  logic [1:0]        req_size = '0;
  logic [1:0]        req_cmd = '0;
  logic              kill = 1'b0;
  logic [NE*8-1:0]   pmp_cfg = '0;
  logic [NE*PW-1:0]  pmp_addr = '0;
  logic              busy, resp_valid;
  logic              resp_ready = 1'b0;
  logic              resp_r, resp_w, resp_x, resp_fault, resp_hit;
  logic [3:0]        resp_idx;

  logic [7:0]        cfg_arr [NE];
  logic [PW-1:0]     pa_arr  [NE];

  logic              exp_r, exp_w, exp_x, exp_fault, exp_hit;
  int                exp_idx, exp_lat;
  int                n_checks = 0;
  int                n_fail = 0;

  pmp_scan_checker #(.NUM_ENTRIES(NE), .ADDR_W(AW), .LANES(LN)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_prv    (req_prv),
    .req_addr   (req_addr),
    .req_size   (req_size),
    .req_cmd    (req_cmd),
    .kill       (kill),
    .pmp_cfg    (pmp_cfg),
    .pmp_addr   (pmp_addr),
    .busy       (busy),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_r     (resp_r),
    .resp_w     (resp_w),
    .resp_x     (resp_x),
    .resp_fault (resp_fault),
    .resp_hit   (resp_hit),
    .resp_idx   (resp_idx)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic clear_cfg();
    for (int i = 0; i < NE; i++) begin
      cfg_arr[i] = '0;
      pa_arr[i]  = '0;
    end
  endtask

  task automatic apply_cfg();
    for (int i = 0; i < NE; i++) begin
      pmp_cfg[i*8 +: 8]   = cfg_arr[i];
      pmp_addr[i*PW +: PW] = pa_arr[i];
    end
  endtask

  // Region of each entry as a half-open byte range [lo, hi). The first entry that touches the access wins.
  task automatic model(input logic [1:0] prv, input logic [AW-1:0] addr, input logic [1:0] size,
                       input logic [1:0] cmd);
    longint a_lo, a_hi, lo, hi;
    logic   partial, ign, is_m;
    logic [7:0] c;
    int t;
    a_lo    = longint'(addr);
    a_hi    = a_lo + (longint'(1) << size) - 1;
    exp_hit = 1'b0;
    exp_idx = 0;
    partial = 1'b0;
    if (a_hi >= SPACE) begin
      {exp_r, exp_w, exp_x} = 3'b000;
      exp_fault = 1'b1;
      exp_lat   = 0;
      return;
    end
    for (int i = 0; i < NE; i++) begin
      if (!exp_hit) begin
        c  = cfg_arr[i];
        lo = 0;
        hi = 0;
        case (c[4:3])
          2'd1: begin
            if (i > 0) lo = longint'(pa_arr[i-1]) * 4;
            hi = longint'(pa_arr[i]) * 4;
          end
          2'd2: begin
            lo = longint'(pa_arr[i]) * 4;
            hi = lo + 4;
          end
          2'd3: begin
            if (pa_arr[i] == '1) begin
              lo = 0;
              hi = SPACE;
            end else begin
              t = 0;
              while (pa_arr[i][t]) t++;
              lo = longint'((pa_arr[i] >> t) << t) * 4;
              hi = lo + (longint'(1) << (t + 3));
            end
          end
          default: ;
        endcase
        if (hi > lo && a_lo < hi && a_hi >= lo) begin
          exp_hit = 1'b1;
          exp_idx = i;
          partial = !(a_lo >= lo && a_hi < hi);
        end
      end
    end
    is_m = (prv == 2'd3);
    if (exp_hit) begin
      ign   = is_m && !cfg_arr[exp_idx][7];
      exp_r = (cfg_arr[exp_idx][0] | ign) & ~partial;
      exp_w = (cfg_arr[exp_idx][1] | ign) & ~partial;
      exp_x = (cfg_arr[exp_idx][2] | ign) & ~partial;
      exp_lat = exp_idx / LN + 2;
    end else begin
      {exp_r, exp_w, exp_x} = {3{is_m}};
      exp_lat = NE / LN + 1;
    end
    case (cmd)
      2'd0:    exp_fault = !exp_r;
      2'd1:    exp_fault = !exp_w;
      2'd2:    exp_fault = !exp_x;
      default: exp_fault = 1'b1;
    endcase
  endtask

  task automatic check_resp(input string tag);
    check({tag, "_hit"}, resp_hit, exp_hit);
    check({tag, "_idx"}, resp_idx, exp_hit ? exp_idx : 0);
    check({tag, "_rwx"}, {resp_r, resp_w, resp_x}, {exp_r, exp_w, exp_x});
    check({tag, "_fault"}, resp_fault, exp_fault);
  endtask

  task automatic do_req(input string tag, input logic [1:0] prv, input logic [AW-1:0] addr,
                        input logic [1:0] size, input logic [1:0] cmd, input int hold);
    int n;
    logic seen;
    model(prv, addr, size, cmd);
    @(negedge clock);
    check({tag, "_req_ready"}, req_ready, 1'b1);
    req_valid = 1'b1;
    req_prv   = prv;
    req_addr  = addr;
    req_size  = size;
    req_cmd   = cmd;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    check({tag, "_busy"}, {busy, req_ready}, 2'b10);
    n    = 0;
    seen = resp_valid;
    while (!seen && n < 40) begin
      @(posedge clock);
      n++;
      @(negedge clock);
      seen = resp_valid;
    end
    if (!seen) begin
      check({tag, "_timeout"}, 1'b0, 1'b1);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      return;
    end
    check({tag, "_latency"}, n, exp_lat);
    check_resp(tag);
    for (int h = 0; h < hold; h++) begin
      @(posedge clock);
      @(negedge clock);
      check({tag, "_hold_valid"}, resp_valid, 1'b1);
      check_resp({tag, "_hold"});
    end
    resp_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    resp_ready = 1'b0;
    check({tag, "_done"}, {req_ready, resp_valid, busy}, 3'b100);
  endtask

  task automatic random_cfg();
    logic [1:0]    mode;
    logic [PW-1:0] base;
    int t;
    for (int i = 0; i < NE; i++) begin
      mode = 2'($urandom);
      base = PW'(32'h2000_0000 + $urandom_range(0, 'h480));
      cfg_arr[i] = {1'($urandom), 2'($urandom), mode, 3'($urandom)};
      if (mode == 2'd3) begin
        t = $urandom_range(0, 9);
        pa_arr[i] = (base & ~((PW'(1) << (t + 1)) - PW'(1))) | ((PW'(1) << t) - PW'(1));
      end else begin
        pa_arr[i] = base;
      end
    end
    apply_cfg();
  endtask

  initial begin
    logic [1:0]    rp;
    logic [AW-1:0] ra;

    clear_cfg();
    apply_cfg();
    #12;
    check("rst_outputs", {req_ready, busy, resp_valid, resp_r, resp_w, resp_x, resp_fault, resp_hit},
          8'b1000_0000);
    check("rst_idx", resp_idx, 0);
    @(negedge clock);
    reset = 1'b0;

    // NAPOT entry 5, 4 KiB at 0x8000_0000, read-only and unlocked
    cfg_arr[5] = 8'h19;
    pa_arr[5]  = 32'h2000_01FF;
    apply_cfg();
    do_req("napot_u_rd", 2'd0, 34'h0_8000_0010, 2'd2, 2'd0, 0);
    do_req("napot_u_wr", 2'd0, 34'h0_8000_0010, 2'd2, 2'd1, 0);
    do_req("napot_m_wr", 2'd3, 34'h0_8000_0010, 2'd2, 2'd1, 0);
    cfg_arr[5] = 8'h99;
    apply_cfg();
    do_req("napot_ml_wr", 2'd3, 34'h0_8000_0010, 2'd2, 2'd1, 0);

    // TOR entry 0 straddled by an 8-byte read
    clear_cfg();
    cfg_arr[0] = 8'h0B;
    pa_arr[0]  = 32'h1000_0000;
    apply_cfg();
    do_req("tor_partial", 2'd0, 34'h0_3FFF_FFFC, 2'd3, 2'd0, 0);

    // Lower-indexed NAPOT beats NA4 entry 12
    clear_cfg();
    cfg_arr[12] = 8'h14;
    pa_arr[12]  = 32'h0000_0040;
    cfg_arr[3]  = 8'h19;
    pa_arr[3]   = 32'h0000_01FF;
    apply_cfg();
    do_req("prio_fetch", 2'd0, 34'h0_0000_0100, 2'd2, 2'd2, 0);

    // Nothing enabled: full scan, then default result
    clear_cfg();
    apply_cfg();
    do_req("none_u", 2'd0, 34'h0, 2'd2, 2'd0, 0);
    do_req("none_m", 2'd3, 34'h0, 2'd2, 2'd0, 0);
    do_req("none_rsvd", 2'd3, 34'h0, 2'd0, 2'd3, 0);

    // Carry out of the address space
    do_req("carry", 2'd3, 34'h3_FFFF_FFFC, 2'd3, 2'd0, 0);

    // Back-pressure: the response must hold for 10 cycles
    cfg_arr[5] = 8'h19;
    pa_arr[5]  = 32'h2000_01FF;
    apply_cfg();
    do_req("hold", 2'd0, 34'h0_8000_0010, 2'd2, 2'd0, 10);

    // Kill mid-scan
    clear_cfg();
    apply_cfg();
    @(negedge clock);
    req_valid = 1'b1;
    req_addr  = '0;
    req_size  = 2'd0;
    req_cmd   = 2'd0;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    @(negedge clock);
    kill = 1'b1;
    @(posedge clock);
    @(negedge clock);
    kill = 1'b0;
    check("kill_idle", {req_ready, busy, resp_valid}, 3'b100);
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      check("kill_no_resp", resp_valid, 1'b0);
    end

    // Asynchronous reset mid-scan
    @(negedge clock);
    req_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    #2 reset = 1'b1;
    #1 check("areset_idle", {req_ready, busy, resp_valid}, 3'b100);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      check("areset_no_resp", resp_valid, 1'b0);
    end
    do_req("after_reset", 2'd3, 34'h0_0000_0040, 2'd1, 2'd1, 0);

    // Randomized tables and requests
    for (int it = 0; it < 64; it++) begin
      if (it % 8 == 0) random_cfg();
      rp = ($urandom_range(0, 2) == 2) ? 2'd3 : 2'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) ra = 34'h3_FFFF_FFF8 + AW'($urandom_range(0, 7));
      else                           ra = 34'h0_8000_0000 + AW'($urandom_range(0, 'h1300));
      do_req("rand", rp, ra, 2'($urandom), 2'($urandom), $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
